// File: rtl/mil1553_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mil1553_pkg                                                  |
// | Description : Shared definitions for the MIL-STD-1553 remote terminal:     |
// |               command/status word bit fields, responder state encoding and |
// |               small helpers for word-count decode and status assembly.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mil1553_pkg;

  // Command word fields
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 11;
  localparam int TR_BIT   = 10;
  localparam int WC_MSB   = 4;
  localparam int WC_LSB   = 0;

  // Status word: message-error flag position
  localparam int ME_BIT   = 10;

  localparam logic [4:0] BCAST_ADDR = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX_DATA   = 3'd1,
    ST_GAP       = 3'd2,
    ST_TX_STATUS = 3'd3,
    ST_TX_DATA   = 3'd4,
    ST_ERR_WAIT  = 3'd5
  } state_t;

  // A word-count field of zero means 32 words.
  function automatic logic [5:0] decode_wc(input logic [4:0] field);
    return (field == 5'd0) ? 6'd32 : {1'b0, field};
  endfunction

  function automatic logic [15:0] status_word(input logic [4:0] addr, input logic me);
    logic [15:0] w;
    w                    = '0;
    w[ADDR_MSB:ADDR_LSB] = addr;
    w[ME_BIT]            = me;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mil_rt_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mil_rt_buffer                                                |
// | Description : 32 x 16 single-port message buffer. Write and read are both  |
// |               synchronous; read data appears one cycle after the address.  |
// |               Contents are not reset.                                      |
// | Ports       : clk   - clock                                                |
// |               we    - write enable                                         |
// |               addr  - word address (shared by read and write)              |
// |               wdata - write data                                           |
// |               rdata - registered read data                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mil_rt_buffer (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);

  logic [15:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/mil_rt_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mil_rt_responder                                             |
// | Description : MIL-STD-1553 remote-terminal message controller. Decodes     |
// |               command words addressed to this RT (or broadcast receive),   |
// |               stores received data words, and after the response gap       |
// |               sequences the transmitter for the status word and any        |
// |               transmit data words.                                         |
// | Ports       : clk, rst          - clock, async active-high reset           |
// |               my_addr           - own RT address                           |
// |               rx_dat/rx_ok/rx_cw - decoded receive word, strobe, sync type |
// |               tx_rdy            - transmitter idle                         |
// |               tx_dat/tx_start/tx_cw - word, start strobe, sync type        |
// |               msg_done          - pulse on completion of a valid message   |
// |               msg_err           - message-error flag (sticky)              |
// |               busy              - FSM not idle                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mil_rt_responder
  import mil1553_pkg::*;
#(
  parameter int GAP_CLKS     = 16,
  parameter int WORD_TO_CLKS = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  my_addr,
  input  logic [15:0] rx_dat,
  input  logic        rx_ok,
  input  logic        rx_cw,
  input  logic        tx_rdy,
  output logic [15:0] tx_dat,
  output logic        tx_start,
  output logic        tx_cw,
  output logic        msg_done,
  output logic        msg_err,
  output logic        busy
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CLKS - 1);
  localparam logic [15:0] TO_LAST  = 16'(WORD_TO_CLKS - 1);

  state_t      state;
  logic [4:0]  idx;       // buffer index, shared by receive and transmit
  logic [5:0]  wc;        // decoded word count, 1..32
  logic [5:0]  cnt;       // words handled so far in this message
  logic [15:0] timer;     // gap / inter-word timeout / silence counter
  logic        is_tx;
  logic        is_bcast;
  logic        me;
  logic        sent;      // status word already launched in TX_STATUS

  logic [4:0]  cmd_addr;
  logic        cmd_tr;
  logic        cmd_accept;
  logic        buf_we;
  logic [15:0] buf_rdata;
  logic        unused_sa;

  assign cmd_addr  = rx_dat[ADDR_MSB:ADDR_LSB];
  assign cmd_tr    = rx_dat[TR_BIT];
  assign unused_sa = ^rx_dat[9:5];

  // Broadcast is only legal for receive; own address 31 is never matched.
  assign cmd_accept = rx_ok && rx_cw &&
                      (((cmd_addr == my_addr) && (cmd_addr != BCAST_ADDR)) ||
                       ((cmd_addr == BCAST_ADDR) && !cmd_tr));

  assign buf_we  = (state == ST_RX_DATA) && rx_ok && !rx_cw;
  assign busy    = (state != ST_IDLE);
  assign msg_err = me;

  // The buffer address is always idx, so while waiting for tx_rdy the read
  // data for the next transmit word is already sitting in buf_rdata.
  mil_rt_buffer u_buffer (
    .clk   (clk),
    .we    (buf_we),
    .addr  (idx),
    .wdata (rx_dat),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      wc       <= '0;
      cnt      <= '0;
      timer    <= '0;
      is_tx    <= 1'b0;
      is_bcast <= 1'b0;
      me       <= 1'b0;
      sent     <= 1'b0;
      tx_dat   <= '0;
      tx_start <= 1'b0;
      tx_cw    <= 1'b0;
      msg_done <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      msg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_accept) begin
            idx      <= '0;
            cnt      <= '0;
            timer    <= '0;
            sent     <= 1'b0;
            wc       <= decode_wc(rx_dat[WC_MSB:WC_LSB]);
            is_tx    <= cmd_tr;
            is_bcast <= (cmd_addr == BCAST_ADDR);
            state    <= cmd_tr ? ST_GAP : ST_RX_DATA;
          end
        end

        ST_RX_DATA: begin
          if (rx_ok) begin
            timer <= '0;
            if (rx_cw) begin
              me    <= 1'b1;
              state <= ST_ERR_WAIT;
            end else begin
              idx <= idx + 5'd1;
              cnt <= cnt + 6'd1;
              if ((cnt + 6'd1) == wc) begin
                state <= ST_GAP;
              end
            end
          end else if (timer == TO_LAST) begin
            timer <= '0;
            me    <= 1'b1;
            state <= ST_ERR_WAIT;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        ST_GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (is_bcast) begin
              msg_done <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              state <= ST_TX_STATUS;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end

        // tx_rdy may still read high while our own tx_start is visible, so
        // completion is only recognised once the strobe has gone away.
        ST_TX_STATUS: begin
          if (!sent) begin
            if (tx_rdy) begin
              tx_start <= 1'b1;
              tx_dat   <= status_word(my_addr, me);
              tx_cw    <= 1'b1;
              sent     <= 1'b1;
            end
          end else if (tx_rdy && !tx_start) begin
            sent <= 1'b0;
            if (is_tx) begin
              idx   <= '0;
              cnt   <= '0;
              state <= ST_TX_DATA;
            end else begin
              msg_done <= 1'b1;
              me       <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end

        ST_TX_DATA: begin
          if (tx_rdy && !tx_start) begin
            if (cnt == wc) begin
              msg_done <= 1'b1;
              me       <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              tx_start <= 1'b1;
              tx_dat   <= buf_rdata;
              tx_cw    <= 1'b0;
              idx      <= idx + 5'd1;
              cnt      <= cnt + 6'd1;
            end
          end
        end

        ST_ERR_WAIT: begin
          if (rx_ok) begin
            timer <= '0;
          end else if (timer == TO_LAST) begin
            timer <= '0;
            state <= ST_IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mil_rt_responder.md
Name: mil_rt_responder

Overview:
- MIL-STD-1553 Remote Terminal (RT) message controller; the responding end of the bus, opposite the bus-controller side that issues commands.
- Takes decoded words from the Manchester receiver (data, valid strobe, sync type) and checks each command word against its own RT address.
- Stores received data words in an internal 32x16 buffer, or returns buffer contents for transmit commands.
- Sequences the Manchester transmitter to send the status word and any data words after the required response gap.

Parameters:
- GAP_CLKS, 16, clocks from end of last received word to status start (response gap).
- WORD_TO_CLKS, 48, max clocks allowed between consecutive received data words before timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- my_addr  in  5  own RT address (0..30)
- rx_dat  in  16  decoded word from receiver
- rx_ok  in  1  one-cycle strobe, rx_dat valid with good parity
- rx_cw  in  1  sync type of the strobed word: 1 = command/status sync, 0 = data sync
- tx_rdy  in  1  transmitter idle; drops the cycle after tx_start
- tx_dat  out  16  word to transmit, held stable while tx_start=1
- tx_start  out  1  one-cycle start strobe
- tx_cw  out  1  sync type for tx word: 1 = status, 0 = data
- msg_done  out  1  one-cycle pulse on completion of a valid message
- msg_err  out  1  message-error flag (sticky)
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: all outputs 0; FSM IDLE; word counter, gap/timeout counters and me flag cleared. Buffer contents are undefined.
- Command decode, on rx_ok & rx_cw in IDLE: addr = rx_dat[15:11], T/R = rx_dat[10], wc = rx_dat[4:0] (0 means 32). Subaddress rx_dat[9:5] is ignored.
- A command word is accepted when addr == my_addr, or when addr == 31 (broadcast) and T/R = 0. Any other command word is ignored and the FSM stays in IDLE.
- Broadcast transmit (addr 31, T/R = 1) is illegal: ignored, no response.
- FSM states: IDLE, RX_DATA, GAP, TX_STATUS, TX_DATA, ERR_WAIT.
- IDLE -> RX_DATA on an accepted receive command (T/R = 0). IDLE -> GAP on an accepted transmit command (T/R = 1).
- RX_DATA:
  - Each rx_ok with rx_cw = 0 writes rx_dat to buffer[index], then increments index.
  - After the wc-th word: go to GAP.
  - Failure conditions: rx_ok with rx_cw = 1, or WORD_TO_CLKS elapsed with no rx_ok. On failure set me = 1 and go to ERR_WAIT.
- GAP: count GAP_CLKS cycles, then:
  - broadcast: pulse msg_done and return to IDLE; no status is sent.
  - otherwise: go to TX_STATUS.
- TX_STATUS:
  - Wait for tx_rdy = 1, then drive tx_dat = {my_addr, me, 10'b0} and tx_cw = 1, and pulse tx_start.
  - When tx_rdy is high again: transmit command -> TX_DATA with index = 0; receive command -> pulse msg_done, clear me, go to IDLE.
- TX_DATA: for each of wc words, wait for tx_rdy = 1, drive tx_dat = buffer[index] and tx_cw = 0, pulse tx_start, increment index. After the last word and tx_rdy high: pulse msg_done, clear me, go to IDLE.
- ERR_WAIT: no response is sent. Return to IDLE after WORD_TO_CLKS of bus silence; any rx_ok restarts that count. me stays set until the next status word has been transmitted.
- msg_err mirrors me.
- Command word arriving while the FSM is in GAP, TX_STATUS or TX_DATA: ignored (no superseding in this revision).
- Buffer read is synchronous, 1-cycle latency. The address is prefetched so that tx_dat is valid on the same cycle as tx_start.
- Word count arithmetic: 5-bit field, 0 maps to 32, giving a 6-bit counter. The index wraps 31 -> 0 only after completion.
- Reset asserted mid-message: immediate return to IDLE, tx_start = 0 on the next edge.

Decomposition:
- Package mil1553_pkg:
  - bit-field constants: ADDR_MSB/LSB, TR_BIT, WC_MSB/LSB, BCAST_ADDR = 31, ME_BIT = 10.
  - state enum.
- One sub-module, mil_rt_buffer: 32x16 single-port RAM, synchronous read and write, no reset.

Test Plan:
- my_addr = 5; command 16'h2822 (addr 5, R, sa 1, wc 2); data 16'hA5A5, 16'h5A5A -> after GAP_CLKS, one tx_start with tx_dat = 16'h2800, tx_cw = 1; msg_done pulse; buffer[0..1] hold the written values.
- Then command 16'h2C22 (addr 5, T, wc 2) -> status 16'h2800, followed by data 16'hA5A5, 16'h5A5A with tx_cw = 0; exactly 3 tx_start pulses total.
- Broadcast 16'hF821 (addr 31, R, wc 1) plus one data word -> no tx_start; msg_done after GAP_CLKS.
- Receive command wc = 3 with only 2 data words, then silence -> no tx_start; msg_err = 1. The next valid receive yields status 16'h2C00 (ME set), after which msg_err = 0.
- Command 16'h3022 (addr 6) -> busy stays 0, no tx_start. wc = 0 receive command accepts exactly 32 words before status.
- rst asserted during TX_DATA after the 1st word -> outputs 0, FSM IDLE; no further tx_start after release.
